// File: rtl/datapath_mc.sv
// Multicycle Fetch/Exec/Writeback datapath executing sll, srl, addi and li
// against an external instruction-memory handshake, with a debug register read port.
module datapath_mc #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned IMM_W   = 3,
  parameter int unsigned PC_W    = 5,
  parameter int unsigned INSTR_W = 2 + REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               retire,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int unsigned NREG = 2 ** REG_AW;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   alu_c;
  logic [DATA_W-1:0]   regs [NREG];
  logic [1:0]          op;
  logic [REG_AW-1:0]   rd;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_sext;
  logic [DATA_W-1:0]   rd_val;
  logic                fetch_c;
  logic                wb_c;

  // Instruction field decode from the latched instruction word
  assign op       = ir[INSTR_W-1 -: 2];
  assign rd       = ir[IMM_W +: REG_AW];
  assign imm      = ir[IMM_W-1:0];
  assign imm_sext = DATA_W'($signed(imm));
  assign rd_val   = regs[rd];

  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_addr];

  // ALU: rd is both source and destination
  always_comb begin
    alu_c = '0;
    case (op)
      2'b00:   alu_c = (32'(imm) >= DATA_W) ? '0 : (rd_val << imm);
      2'b01:   alu_c = (32'(imm) >= DATA_W) ? '0 : (rd_val >> imm);
      2'b10:   alu_c = rd_val + imm_sext;
      default: alu_c = imm_sext;
    endcase
  end

  // Next-state and handshake outputs; Reset forces all strobes low
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    retire     = 1'b0;
    busy       = 1'b0;
    fetch_c    = 1'b0;
    wb_c       = 1'b0;
    case (state)
      FETCH: begin
        imem_req = run;
        busy     = run && !imem_valid;
        if (run && imem_valid) begin
          fetch_c    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = WB;
      end
      WB: begin
        busy       = 1'b1;
        retire     = 1'b1;
        wb_c       = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (Reset) begin
      imem_req = 1'b0;
      retire   = 1'b0;
      busy     = 1'b0;
    end
  end

  // State, instruction/result registers, register file and pc
  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      result <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[REG_AW'(i)] <= '0;
      end
    end else begin
      state <= state_next;
      if (fetch_c) begin
        ir <= imem_data;
      end
      if (state == EXEC) begin
        result <= alu_c;
      end
      if (wb_c) begin
        regs[rd] <= result;
        pc       <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// Bench for datapath_mc: vector table, hand-written corner sequences and a
// randomized run against an arithmetic reference model; a second 16-bit/PC_W=2 instance.
module tb_datapath_mc;

  logic       clk = 1'b0;
  logic       reset, run, valid;
  logic [2:0] dbg_addr;
  logic       imem_req, busy, retire;
  logic [4:0] imem_addr, pc;
  logic [7:0] imem_data, dbg_data;
  logic [7:0] imem [32];

  logic        a_reset, a_run, a_valid;
  logic [2:0]  a_dbg_addr;
  logic        a_req, a_busy, a_retire;
  logic [1:0]  a_addr, a_pc;
  logic [7:0]  a_data;
  logic [15:0] a_dbg;
  logic [7:0]  aim [4];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int t0, t1, last_ret, last_dbg;
  int mregs [8];
  int mpc;

  typedef struct {
    logic [7:0] instr;
    int         rd;
    int         exp;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  assign imem_data = imem[imem_addr];
  assign a_data    = aim[a_addr];

  datapath_mc u_dut (
    .clk(clk), .Reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(valid),
    .pc(pc), .busy(busy), .retire(retire), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  datapath_mc #(.DATA_W(16), .PC_W(2)) u_alt (
    .clk(clk), .Reset(a_reset), .run(a_run),
    .imem_req(a_req), .imem_addr(a_addr), .imem_data(a_data), .imem_valid(a_valid),
    .pc(a_pc), .busy(a_busy), .retire(a_retire), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference semantics from the ISA rules, using plain integer arithmetic
  function automatic int ref_exec(int op, int r, int imm, int w);
    int md = 1 << w;
    int s  = (imm >= 4) ? imm - 8 : imm;
    case (op)
      0:       return (imm >= w) ? 0 : (r * (1 << imm)) % md;
      1:       return r / (1 << imm);
      2:       return ((r + s) % md + md) % md;
      default: return (s + md) % md;
    endcase
  endfunction

  task automatic do_reset(input bit r, input bit v);
    reset = 1'b1;
    run   = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_retire", retire, 0);
    check("rst_req", imem_req, 0);
    reset = 1'b0;
    run   = r;
    valid = v;
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    mpc = 0;
    t0  = ncyc;
  endtask

  // Wait for n retires; each retire advances the model and checks rd and pc
  task automatic run_instrs(input int n, input bit rnd, input bit stop);
    int got = 0;
    int cyc = 0;
    int op_i, rd_i, imm_i;
    while (got < n && cyc < n * 60) begin
      if (rnd) begin
        valid = ($urandom_range(0, 3) != 0);
        run   = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);
      cyc++;
      if (retire === 1'b1) begin
        op_i  = int'(imem[mpc][7:6]);
        rd_i  = int'(imem[mpc][5:3]);
        imm_i = int'(imem[mpc][2:0]);
        mregs[rd_i] = ref_exec(op_i, mregs[rd_i], imm_i, 8);
        mpc = (mpc + 1) % 32;
        got++;
        last_ret = ncyc;
        if (stop && got == n) run = 1'b0;
        dbg_addr = 3'(rd_i);
        @(negedge clk);
        cyc++;
        last_dbg = int'(dbg_data);
        check("model_reg", dbg_data, mregs[rd_i]);
        check("model_pc", pc, mpc);
      end
    end
    if (got < n) check("retire_timeout", got, n);
  endtask

  initial begin
    int aexp [5];
    int ar [5];
    int apc [5];
    int cyc;
    bit seen;

    reset = 1'b1; run = 1'b0; valid = 1'b0; dbg_addr = '0;
    a_reset = 1'b1; a_run = 1'b0; a_valid = 1'b0; a_dbg_addr = '0;

    vt[0] = '{8'hD9, 3, 8'h01};
    vt[1] = '{8'h1A, 3, 8'h04};
    vt[2] = '{8'hD4, 2, 8'hFC};
    vt[3] = '{8'h14, 2, 8'hC0};
    vt[4] = '{8'h22, 4, 8'h00};
    vt[5] = '{8'hCF, 1, 8'hFF};
    vt[6] = '{8'h4B, 1, 8'h1F};
    vt[7] = '{8'h89, 1, 8'h20};
    vt[8] = '{8'hEB, 5, 8'h03};
    vt[9] = '{8'hAC, 5, 8'hFF};

    // Table program: first five back to back, the rest with random gaps
    for (int i = 0; i < 32; i++) imem[i] = 8'h00;
    for (int i = 0; i < 10; i++) imem[i] = vt[i].instr;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_instrs(1, i >= 5, i == 4);
      check("table_reg", last_dbg, vt[i].exp);
      if (i == 4) begin
        check("five_in_15", last_ret - t0 + 1, 15);
        check("pc_after5", pc, 5);
        check("req_idle", imem_req, 0);
        dbg_addr = 3'd3; #1 check("r3", dbg_data, 8'h04);
        dbg_addr = 3'd2; #1 check("r2", dbg_data, 8'hC0);
        dbg_addr = 3'd4; #1 check("r4", dbg_data, 8'h00);
        run = 1'b1;
      end
    end

    // Instruction memory not valid for four FETCH cycles
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("gap_busy", busy, 1);
      check("gap_req", imem_req, 1);
      check("gap_pc", pc, 0);
      check("gap_retire", retire, 0);
      @(negedge clk);
    end
    valid = 1'b1;
    t1 = ncyc;
    #1 check("valid_busy", busy, 0);
    run_instrs(1, 1'b0, 1'b1);
    check("valid_latency", last_ret - t1, 2);

    // run dropped while li R6,2 is in flight
    imem[0] = 8'hF2;
    imem[1] = 8'hD9;
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    run = 1'b0;
    run_instrs(1, 1'b0, 1'b0);
    check("r6", last_dbg, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("norun_req", imem_req, 0);
      check("norun_retire", retire, 0);
    end
    check("norun_pc", pc, 1);
    check("norun_busy", busy, 0);
    run = 1'b1;
    #1 check("rerun_req", imem_req, 1);
    run_instrs(1, 1'b0, 1'b1);

    // Reset during EXEC of sll R3,2
    imem[1] = 8'h1A;
    do_reset(1'b1, 1'b1);
    run_instrs(1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("exrst_retire", retire, 0);
    check("exrst_busy", busy, 0);
    check("exrst_req", imem_req, 0);
    @(negedge clk);
    check("exrst_pc", pc, 0);
    check("exrst_retire2", retire, 0);
    dbg_addr = 3'd3;
    #1 check("exrst_r3", dbg_data, 0);
    reset = 1'b0;
    run   = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (retire !== 1'b0) seen = 1'b1;
    end
    check("exrst_no_retire", seen, 0);

    // Randomized program and handshake against the model
    for (int i = 0; i < 32; i++) imem[i] = 8'($urandom);
    do_reset(1'b1, 1'b1);
    run_instrs(70, 1'b1, 1'b0);
    run = 1'b0;

    // 16-bit data, 2-bit pc: wrap and re-execute address 0
    aim[0] = 8'hFF; aim[1] = 8'hB9; aim[2] = 8'hCB; aim[3] = 8'h0B;
    aexp = '{32'hFFFF, 32'h0, 32'h3, 32'h18, 32'hFFFF};
    ar   = '{7, 7, 1, 1, 7};
    apc  = '{1, 2, 3, 0, 1};
    @(negedge clk);
    @(negedge clk);
    a_dbg_addr = 3'd7;
    #1 check("alt_rst_r7", a_dbg, 0);
    check("alt_rst_pc", a_pc, 0);
    a_reset = 1'b0; a_run = 1'b1; a_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (a_retire === 1'b1) seen = 1'b1;
      end
      check("alt_retire_seen", seen, 1);
      a_dbg_addr = 3'(ar[k]);
      @(negedge clk);
      check("alt_reg", a_dbg, aexp[k]);
      check("alt_pc", a_pc, apc[k]);
    end
    a_run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
